// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer: scratchpad and control stage for one PE MAC.
// Loads a filter row and an ifmap row, then steps the external MAC through a
// 1-D row convolution, accumulating each output onto a psum from the PE above.
module pe_row_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PSUM_WIDTH  = 32,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IFMAP_LEN   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  reuse_w,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] act_data,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [DATA_WIDTH-1:0] psum_in_data,
    input  logic                  psum_in_valid,
    output logic                  psum_in_ready,
    output logic [DATA_WIDTH-1:0] psum_out_data,
    output logic                  psum_out_valid,
    input  logic                  psum_out_ready,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_w,
    output logic [DATA_WIDTH-1:0] mac_sum,
    output logic                  mac_en,
    input  logic [PSUM_WIDTH-1:0] mac_out,
    output logic                  done,
    output logic                  weights_valid
);

    localparam int unsigned NUM_OUT = IFMAP_LEN - KERNEL_SIZE + 1;
    localparam int unsigned KW      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int unsigned LW      = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_A,
        S_WAIT_P,
        S_COMPUTE,
        S_DRAIN,
        S_OUTPUT
    } state_e;

    state_e                state_q;
    logic [KW-1:0]         w_cnt_q;
    logic [LW-1:0]         a_cnt_q;
    logic [LW-1:0]         j_q;
    logic [KW-1:0]         k_q;
    logic                  w_ready_q;
    logic                  act_ready_q;
    logic                  psum_in_ready_q;
    logic                  psum_out_valid_q;
    logic [DATA_WIDTH-1:0] psum_out_data_q;
    logic [DATA_WIDTH-1:0] mac_a_q;
    logic [DATA_WIDTH-1:0] mac_w_q;
    logic [DATA_WIDTH-1:0] mac_sum_q;
    logic                  mac_en_q;
    logic                  done_q;
    logic                  weights_valid_q;

    logic [DATA_WIDTH-1:0] w_spad [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] a_spad [IFMAP_LEN];

    // Upper MAC result bits are intentionally dropped (sums wrap at DATA_WIDTH).
    logic unused_mac_hi;
    assign unused_mac_hi = ^mac_out[PSUM_WIDTH-1:DATA_WIDTH];

    // Scratchpad writes; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_ready_q && w_valid) begin
            w_spad[w_cnt_q] <= w_data;
        end
        if (act_ready_q && act_valid) begin
            a_spad[a_cnt_q] <= act_data;
        end
    end

    // Row sequencer FSM with registered handshake and MAC control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            w_cnt_q          <= '0;
            a_cnt_q          <= '0;
            j_q              <= '0;
            k_q              <= '0;
            w_ready_q        <= 1'b0;
            act_ready_q      <= 1'b0;
            psum_in_ready_q  <= 1'b0;
            psum_out_valid_q <= 1'b0;
            psum_out_data_q  <= '0;
            mac_a_q          <= '0;
            mac_w_q          <= '0;
            mac_sum_q        <= '0;
            mac_en_q         <= 1'b0;
            done_q           <= 1'b0;
            weights_valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (reuse_w && weights_valid_q) begin
                            state_q     <= S_LOAD_A;
                            act_ready_q <= 1'b1;
                            a_cnt_q     <= '0;
                        end else begin
                            state_q         <= S_LOAD_W;
                            w_ready_q       <= 1'b1;
                            w_cnt_q         <= '0;
                            weights_valid_q <= 1'b0;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        if (w_cnt_q == KW'(KERNEL_SIZE - 1)) begin
                            weights_valid_q <= 1'b1;
                            w_ready_q       <= 1'b0;
                            act_ready_q     <= 1'b1;
                            a_cnt_q         <= '0;
                            state_q         <= S_LOAD_A;
                        end else begin
                            w_cnt_q <= w_cnt_q + KW'(1);
                        end
                    end
                end
                S_LOAD_A: begin
                    if (act_valid) begin
                        if (a_cnt_q == LW'(IFMAP_LEN - 1)) begin
                            act_ready_q     <= 1'b0;
                            psum_in_ready_q <= 1'b1;
                            j_q             <= '0;
                            state_q         <= S_WAIT_P;
                        end else begin
                            a_cnt_q <= a_cnt_q + LW'(1);
                        end
                    end
                end
                S_WAIT_P: begin
                    // First tap is presented on the cycle after the psum arrives.
                    if (psum_in_valid) begin
                        psum_in_ready_q <= 1'b0;
                        mac_sum_q       <= psum_in_data;
                        mac_a_q         <= a_spad[j_q];
                        mac_w_q         <= w_spad[0];
                        mac_en_q        <= 1'b1;
                        k_q             <= '0;
                        state_q         <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    // Capture the sum actually presented so it holds once mac_en drops.
                    mac_sum_q <= mac_sum;
                    if (k_q == KW'(KERNEL_SIZE - 1)) begin
                        mac_en_q <= 1'b0;
                        state_q  <= S_DRAIN;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        mac_a_q <= a_spad[j_q + LW'(k_q) + LW'(1)];
                        mac_w_q <= w_spad[k_q + KW'(1)];
                    end
                end
                S_DRAIN: begin
                    psum_out_data_q  <= mac_out[DATA_WIDTH-1:0];
                    psum_out_valid_q <= 1'b1;
                    state_q          <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (psum_out_ready) begin
                        psum_out_valid_q <= 1'b0;
                        if (j_q == LW'(NUM_OUT - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            j_q             <= j_q + LW'(1);
                            psum_in_ready_q <= 1'b1;
                            state_q         <= S_WAIT_P;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Chained taks take the previous MAC result straight from the MAC register.
    assign mac_sum = (state_q == S_COMPUTE && k_q != '0) ? mac_out[DATA_WIDTH-1:0] : mac_sum_q;

    assign w_ready        = w_ready_q;
    assign act_ready      = act_ready_q;
    assign psum_in_ready  = psum_in_ready_q;
    assign psum_out_valid = psum_out_valid_q;
    assign psum_out_data  = psum_out_data_q;
    assign mac_a          = mac_a_q;
    assign mac_w          = mac_w_q;
    assign mac_en         = mac_en_q;
    assign done           = done_q;
    assign weights_valid  = weights_valid_q;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Testbench for pe_row_sequencer with a behavioural registered MAC.
module tb_pe_row_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned K  = 3;
    localparam int unsigned L  = 8;
    localparam int unsigned N  = L - K + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          reuse_w;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] act_data;
    logic          act_valid;
    logic          act_ready;
    logic [DW-1:0] psum_in_data;
    logic          psum_in_valid;
    logic          psum_in_ready;
    logic [DW-1:0] psum_out_data;
    logic          psum_out_valid;
    logic          psum_out_ready;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_w;
    logic [DW-1:0] mac_sum;
    logic          mac_en;
    logic [PW-1:0] mac_out = '0;
    logic          done;
    logic          weights_valid;

    always #5 clk = ~clk;

    pe_row_sequencer #(
        .DATA_WIDTH (DW),
        .PSUM_WIDTH (PW),
        .KERNEL_SIZE(K),
        .IFMAP_LEN  (L)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .reuse_w       (reuse_w),
        .w_data        (w_data),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .act_data      (act_data),
        .act_valid     (act_valid),
        .act_ready     (act_ready),
        .psum_in_data  (psum_in_data),
        .psum_in_valid (psum_in_valid),
        .psum_in_ready (psum_in_ready),
        .psum_out_data (psum_out_data),
        .psum_out_valid(psum_out_valid),
        .psum_out_ready(psum_out_ready),
        .mac_a         (mac_a),
        .mac_w         (mac_w),
        .mac_sum       (mac_sum),
        .mac_en        (mac_en),
        .mac_out       (mac_out),
        .done          (done),
        .weights_valid (weights_valid)
    );

    // External MAC: registered multiply-accumulate.
    always_ff @(posedge clk) begin
        if (mac_en) mac_out <= PW'(mac_sum) + PW'(mac_a) * PW'(mac_w);
    end

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] wv_arr [K];
    logic [DW-1:0] av_arr [L];
    logic [DW-1:0] pv_arr [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] stall_q [$];
    int            done_cnt;
    bit            w_ready_seen;
    int            pfire_cyc;
    bit            en_hist [512];
    bit            pov_hist [512];

    // Reference: 1-D correlation of the row with the filter, plus psum, mod 2^DW.
    function automatic logic [DW-1:0] model(input int j, input logic [DW-1:0] p);
        logic [DW-1:0] acc;
        acc = p;
        for (int k = 0; k < int'(K); k++) begin
            acc = acc + DW'(PW'(av_arr[j+k]) * PW'(wv_arr[k]));
        end
        return acc;
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; reuse_w = 1'b0;
        w_valid = 1'b0; act_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
        w_data = '0; act_data = '0; psum_in_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one row; records outputs, expectations and timing history. No checks here.
    task automatic drive_row(input bit reuse, input int stall_idx, input int stall_len,
                             input int abort_idx, output bit timed_out);
        int wi, ai, pi, oi, stall_left;
        bit fw, fa, fp, fo;
        wi = 0; ai = 0; pi = 0; oi = 0; stall_left = stall_len;
        done_cnt = 0; w_ready_seen = 1'b0; pfire_cyc = -1;
        exp_q.delete(); got_q.delete(); stall_q.delete();
        for (int i = 0; i < 512; i++) begin en_hist[i] = 1'b0; pov_hist[i] = 1'b0; end
        @(negedge clk); start = 1'b1; reuse_w = reuse;
        @(negedge clk); start = 1'b0; reuse_w = 1'b0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 512; cyc++) begin
            if (done) begin done_cnt++; timed_out = 1'b0; break; end
            en_hist[cyc]  = mac_en;
            pov_hist[cyc] = psum_out_valid;
            w_ready_seen  = w_ready_seen | w_ready;
            if (abort_idx >= 0 && oi == abort_idx && mac_en) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                timed_out = 1'b0;
                break;
            end
            w_valid       = reuse ? 1'b1 : (wi < int'(K));
            w_data        = wv_arr[(wi < int'(K)) ? wi : 0];
            act_valid     = (ai < int'(L));
            act_data      = av_arr[(ai < int'(L)) ? ai : 0];
            psum_in_valid = (pi < int'(N));
            psum_in_data  = pv_arr[(pi < int'(N)) ? pi : 0];
            psum_out_ready = 1'b1;
            if (psum_out_valid && oi == stall_idx && stall_left > 0) begin
                psum_out_ready = 1'b0;
                stall_q.push_back(psum_out_data);
                stall_left--;
            end
            fw = w_valid && w_ready;
            fa = act_valid && act_ready;
            fp = psum_in_valid && psum_in_ready;
            fo = psum_out_valid && psum_out_ready;
            if (fw) wi++;
            if (fa) ai++;
            if (fp) begin
                exp_q.push_back(model(pi, pv_arr[pi]));
                if (pfire_cyc < 0) pfire_cyc = cyc;
                pi++;
            end
            if (fo) begin got_q.push_back(psum_out_data); oi++; end
            @(negedge clk);
        end
        w_valid = 1'b0; act_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({w_ready, act_ready, psum_in_ready, psum_out_valid, mac_en, done, weights_valid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {w_ready, act_ready, psum_in_ready, psum_out_valid, mac_en, done, weights_valid});
        end
        checks++;
        if ({psum_out_data, mac_a, mac_w, mac_sum} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {psum_out_data, mac_a, mac_w, mac_sum});
        end
    endtask

    task automatic test_first_row();
        bit to;
        logic [DW-1:0] g, e;
        for (int i = 0; i < int'(K); i++) wv_arr[i] = DW'(i + 1);
        for (int i = 0; i < int'(L); i++) av_arr[i] = DW'(i + 1);
        for (int i = 0; i < int'(N); i++) pv_arr[i] = '0;
        drive_row(1'b0, -1, 0, -1, to);
        checks++;
        if (to || got_q.size() != int'(N)) begin
            failures++;
            $display("FAIL row1_count got=%0d want=%0d timeout=%0d", got_q.size(), N, to);
        end
        checks++;
        if (got_q.size() > 0 && got_q[0] !== 16'd14) begin
            failures++;
            $display("FAIL row1_first got=%0d want=14", got_q[0]);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL row1_psum got=%0d want=%0d", g, e); end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL row1_done got=%0d want=1", done_cnt); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || weights_valid !== 1'b1) begin
            failures++;
            $display("FAIL row1_after got=done%b wv%b want=done0 wv1", done, weights_valid);
        end
    endtask

    task automatic test_reuse();
        bit to;
        logic [DW-1:0] g, e;
        int idx;
        for (int i = 0; i < int'(L); i++) av_arr[i] = DW'(i + 1);
        for (int i = 0; i < int'(N); i++) pv_arr[i] = 16'd100;
        drive_row(1'b1, -1, 0, -1, to);
        checks++;
        if (to || w_ready_seen) begin
            failures++;
            $display("FAIL reuse_wready got=%0d want=0 timeout=%0d", w_ready_seen, to);
        end
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g !== DW'(114 + 6 * idx)) begin
                failures++;
                $display("FAIL reuse_psum got=%0d want=%0d", g, 114 + 6 * idx);
            end
            idx++;
        end
        checks++;
        if (idx != int'(N)) begin failures++; $display("FAIL reuse_count got=%0d want=%0d", idx, N); end
    endtask

    task automatic test_reuse_after_reset();
        do_reset();
        @(negedge clk); start = 1'b1; reuse_w = 1'b1;
        @(negedge clk); start = 1'b0; reuse_w = 1'b0;
        checks++;
        if (w_ready !== 1'b1 || weights_valid !== 1'b0 || act_ready !== 1'b0) begin
            failures++;
            $display("FAIL reuse_reset got=wr%b wv%b ar%b want=wr1 wv0 ar0", w_ready, weights_valid, act_ready);
        end
        do_reset();
    endtask

    task automatic test_timing();
        bit to;
        int c;
        logic [DW-1:0] g, e;
        for (int i = 0; i < int'(K); i++) wv_arr[i] = DW'(i + 1);
        for (int i = 0; i < int'(L); i++) av_arr[i] = DW'($urandom_range(0, 1000));
        for (int i = 0; i < int'(N); i++) pv_arr[i] = DW'($urandom);
        drive_row(1'b0, -1, 0, -1, to);
        c = pfire_cyc;
        checks++;
        if (to || c < 0) begin failures++; $display("FAIL timing_fire got=%0d want>=0", c); end
        else begin
            checks++;
            if ({en_hist[c], en_hist[c+1], en_hist[c+2], en_hist[c+3], en_hist[c+4]} !== 5'b01110) begin
                failures++;
                $display("FAIL timing_mac_en got=%b want=01110",
                         {en_hist[c], en_hist[c+1], en_hist[c+2], en_hist[c+3], en_hist[c+4]});
            end
            checks++;
            if ({pov_hist[c+4], pov_hist[c+5]} !== 2'b01) begin
                failures++;
                $display("FAIL timing_valid got=%b want=01", {pov_hist[c+4], pov_hist[c+5]});
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL timing_psum got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_wrap();
        bit to;
        int cnt;
        logic [DW-1:0] g, e;
        for (int i = 0; i < int'(K); i++) wv_arr[i] = 16'hFFFF;
        for (int i = 0; i < int'(L); i++) av_arr[i] = 16'hFFFF;
        for (int i = 0; i < int'(N); i++) pv_arr[i] = '0;
        drive_row(1'b0, -1, 0, -1, to);
        cnt = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== 16'h0003 || g !== e) begin
                failures++;
                $display("FAIL wrap_psum got=%h want=0003", g);
            end
            cnt++;
        end
        checks++;
        if (to || cnt != int'(N)) begin failures++; $display("FAIL wrap_count got=%0d want=%0d", cnt, N); end
    endtask

    task automatic test_stall_abort();
        bit to;
        int quiet;
        logic [DW-1:0] g, e;
        wv_arr[0] = 16'd2; wv_arr[1] = 16'd1; wv_arr[2] = 16'd4;
        for (int i = 0; i < int'(L); i++) av_arr[i] = DW'($urandom_range(0, 500));
        for (int i = 0; i < int'(N); i++) pv_arr[i] = DW'($urandom);
        drive_row(1'b0, 1, 10, 3, to);
        checks++;
        if (to || stall_q.size() != 10 || exp_q.size() < 2) begin
            failures++;
            $display("FAIL stall_samples got=%0d want=10 timeout=%0d", stall_q.size(), to);
        end else begin
            foreach (stall_q[i]) begin
                checks++;
                if (stall_q[i] !== exp_q[1]) begin
                    failures++;
                    $display("FAIL stall_hold got=%h want=%h", stall_q[i], exp_q[1]);
                end
            end
        end
        checks++;
        if (got_q.size() != 3) begin failures++; $display("FAIL abort_count got=%0d want=3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL abort_psum got=%h want=%h", g, e); end
        end
        checks++;
        if ({w_ready, act_ready, psum_in_ready, psum_out_valid, mac_en, done, weights_valid} !== 7'b0 ||
            {psum_out_data, mac_a, mac_w, mac_sum} !== '0) begin
            failures++;
            $display("FAIL abort_state got=%b/%h want=0",
                     {w_ready, act_ready, psum_in_ready, psum_out_valid, mac_en, done, weights_valid},
                     {psum_out_data, mac_a, mac_w, mac_sum});
        end
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            psum_in_valid = 1'b1; act_valid = 1'b1; w_valid = 1'b1;
            if (done || psum_out_valid || w_ready || act_ready || psum_in_ready) quiet++;
            @(negedge clk);
        end
        psum_in_valid = 1'b0; act_valid = 1'b0; w_valid = 1'b0;
        checks++;
        if (quiet != 0) begin failures++; $display("FAIL abort_idle got=%0d want=0", quiet); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_row();
        test_reuse();
        test_reuse_after_reset();
        test_timing();
        test_wrap();
        test_stall_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
